// File: rtl/reset_gen_pkg.sv
// Shared constants for reset_gen: register map, CAUSE bit positions, FSM encoding,
// and the bus byte-swap helper.
package reset_gen_pkg;

    localparam logic [1:0] A_WDT_CTRL = 2'd0;
    localparam logic [1:0] A_WDT_LOAD = 2'd1;
    localparam logic [1:0] A_WDT_KICK = 2'd2;
    localparam logic [1:0] A_CAUSE    = 2'd3;

    localparam int CAUSE_POR = 0;
    localparam int CAUSE_BTN = 1;
    localparam int CAUSE_WDT = 2;

    typedef enum logic {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/reset_gen_btn_debounce.sv
// Debouncer for an already-synchronized pushbutton: the level is accepted only after
// DEBOUNCE_CYCLES consecutive cycles of disagreement; rise pulses once per accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_s,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        rise_d   = 1'b0;
        cnt_d    = '0;
        if (btn_s != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = btn_s;
                rise_d   = btn_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;

endmodule

// File: rtl/reset_gen.sv
// Board reset source: stretches rst_n, button and watchdog events into rst_globl and
// keeps a sticky cause register. Watchdog present only when RESET_GEN_WDT_EN is defined.
module reset_gen #(
    parameter int          STRETCH_CYCLES  = 16,
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter logic [31:0] WDT_DEFAULT     = 32'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn,
    input  logic [1:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    output logic        rst_globl
);
    import reset_gen_pkg::*;

    localparam int SW = (STRETCH_CYCLES > 0) ? $clog2(STRETCH_CYCLES + 1) : 1;
    localparam logic [SW-1:0] STR_LOAD = SW'(STRETCH_CYCLES);
    // The synchronizer's releasing edge already counts as one hold cycle.
    localparam logic [SW-1:0] STR_POR  = SW'((STRETCH_CYCLES > 0) ? STRETCH_CYCLES - 1 : 0);

    logic [1:0] rst_sync_q, rst_sync_d;
    logic [1:0] btn_sync_q, btn_sync_d;
    logic       rst_s_n;

    state_e        state_q, state_d;
    logic [SW-1:0] str_q, str_d;
    logic [2:0]    cause_q, cause_d;

    logic        btn_level, btn_rise;
    logic        wr_ok, trigger, wdt_expire;
    logic [31:0] wdata, rdata;
    logic        unused_ok;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign btn_sync_d = {btn_sync_q[0], btn};
    assign rst_s_n    = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
            btn_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
            btn_sync_q <= btn_sync_d;
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_s (btn_sync_q[1]),
        .level (btn_level),
        .rise  (btn_rise)
    );

    assign wdata = bswap(d);
    assign wr_ok = we && (state_q == S_RUN);

`ifdef RESET_GEN_WDT_EN
    logic        wdt_en_q, wdt_en_d;
    logic [31:0] wdt_load_q, wdt_load_d;
    logic [31:0] wdt_cnt_q, wdt_cnt_d;
    logic        kick;

    always_comb begin
        wdt_en_d   = wdt_en_q;
        wdt_load_d = wdt_load_q;
        wdt_cnt_d  = wdt_cnt_q;
        kick       = wr_ok && (a == A_WDT_KICK);
        // A kick landing on the zero-count cycle beats the expiry.
        wdt_expire = (state_q == S_RUN) && wdt_en_q && (wdt_cnt_q == '0) && !kick;
        if ((state_q == S_RUN) && wdt_en_q && (wdt_cnt_q != '0))
            wdt_cnt_d = wdt_cnt_q - 1'b1;
        if (wdt_expire)
            wdt_en_d = 1'b0;
        if (wr_ok) begin
            case (a)
                A_WDT_CTRL: begin
                    wdt_en_d = wdata[0];
                    if (wdata[0]) wdt_cnt_d = wdt_load_q;
                end
                A_WDT_LOAD: wdt_load_d = wdata;
                A_WDT_KICK: wdt_cnt_d  = wdt_load_q;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_en_q   <= 1'b0;
            wdt_load_q <= WDT_DEFAULT;
            wdt_cnt_q  <= WDT_DEFAULT;
        end else begin
            wdt_en_q   <= wdt_en_d;
            wdt_load_q <= wdt_load_d;
            wdt_cnt_q  <= wdt_cnt_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (a)
            A_WDT_CTRL: rdata = {31'b0, wdt_en_q};
            A_WDT_LOAD: rdata = wdt_load_q;
            A_CAUSE:    rdata = {29'b0, cause_q};
            default:    rdata = '0;
        endcase
    end

    assign unused_ok = btn_level;
`else
    assign wdt_expire = 1'b0;

    always_comb begin
        rdata = '0;
        if (a == A_CAUSE) rdata = {29'b0, cause_q};
    end

    assign unused_ok = ^{btn_level, wdata[31:3], WDT_DEFAULT};
`endif

    assign trigger = btn_rise || wdt_expire;

    always_comb begin
        state_d = state_q;
        str_d   = str_q;
        case (state_q)
            S_HOLD: begin
                if (trigger) begin
                    str_d = STR_LOAD;
                end else if (rst_s_n) begin
                    if (str_q == '0) state_d = S_RUN;
                    else             str_d   = str_q - 1'b1;
                end
            end
            S_RUN: begin
                if (trigger) begin
                    state_d = S_HOLD;
                    str_d   = STR_LOAD;
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    // W1C is applied first so a same-cycle set event survives.
    always_comb begin
        cause_d = cause_q;
        if (wr_ok && (a == A_CAUSE))
            cause_d = cause_q & ~wdata[2:0];
        if (btn_rise)
            cause_d[CAUSE_BTN] = 1'b1;
        if (wdt_expire)
            cause_d[CAUSE_WDT] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HOLD;
            str_q   <= STR_POR;
            cause_q <= 3'b001;
        end else begin
            state_q <= state_d;
            str_q   <= str_d;
            cause_q <= cause_d;
        end
    end

    assign rst_globl = (state_q == S_HOLD);
    assign spo       = bswap(rdata);

endmodule
